bsg_vanilla_int_wb_arbiter: RTL and testbench

//  Schedules the single write port of the vanilla core integer regfile among three requesters:
//  - pipeline WB stage
//  - remote load responses with float_wb=0
//  - iterative integer divider results

---
 rtl/bsg_vanilla_int_wb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_bsg_vanilla_int_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_vanilla_int_wb_arbiter.sv
`default_nettype none
// ============================================================================
// bsg_vanilla_int_wb_arbiter: integer regfile write-port arbiter (WB/remote/div)
// Revision: 1.0
// ============================================================================
module bsg_vanilla_int_wb_arbiter #(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5,
  parameter int max_wait_p       = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        wb_v_i,
  input  logic [reg_addr_width_p-1:0] wb_rd_i,
  input  logic [data_width_p-1:0]     wb_data_i,
  output logic                        wb_yumi_o,

  input  logic                        rl_v_i,
  input  logic [reg_addr_width_p-1:0] rl_rd_i,
  input  logic [data_width_p-1:0]     rl_data_i,
  output logic                        rl_yumi_o,

  input  logic                        div_v_i,
  input  logic [reg_addr_width_p-1:0] div_rd_i,
  input  logic [data_width_p-1:0]     div_data_i,
  output logic                        div_yumi_o,

  output logic                        rf_w_v_o,
  output logic [reg_addr_width_p-1:0] rf_w_addr_o,
  output logic [data_width_p-1:0]     rf_w_data_o,

  output logic                        sb_clr_v_o,
  output logic [reg_addr_width_p-1:0] sb_clr_id_o
);

  localparam int cnt_width_lp = $clog2(max_wait_p + 1);
  localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_wait_p);
  localparam logic [cnt_width_lp-1:0] one_cnt_lp = cnt_width_lp'(1);

  logic [cnt_width_lp-1:0] rl_cnt_r,  rl_cnt_n;
  logic [cnt_width_lp-1:0] div_cnt_r, div_cnt_n;
  logic                    rl_starve_r,  rl_starve_n;
  logic                    div_starve_r, div_starve_n;

  logic                        grant_wb, grant_rl, grant_div;
  logic                        grant_any, grant_long;
  logic [reg_addr_width_p-1:0] sel_rd;
  logic [data_width_p-1:0]     sel_data;

  logic                        rf_w_v_r;
  logic [reg_addr_width_p-1:0] rf_w_addr_r;
  logic [data_width_p-1:0]     rf_w_data_r;
  logic                        sb_clr_v_r;
  logic [reg_addr_width_p-1:0] sb_clr_id_r;

  // Starving requesters jump ahead of WB; otherwise WB has the port first.
  // Nothing is granted while reset is held so no request is silently lost.
  always_comb begin
    grant_wb  = 1'b0;
    grant_rl  = 1'b0;
    grant_div = 1'b0;
    if (!reset_i) begin
      if (rl_starve_r && rl_v_i)        grant_rl  = 1'b1;
      else if (div_starve_r && div_v_i) grant_div = 1'b1;
      else if (wb_v_i)                  grant_wb  = 1'b1;
      else if (rl_v_i)                  grant_rl  = 1'b1;
      else if (div_v_i)                 grant_div = 1'b1;
    end
  end

  assign grant_long = grant_rl | grant_div;
  assign grant_any  = grant_wb | grant_long;

  always_comb begin
    sel_rd   = wb_rd_i;
    sel_data = wb_data_i;
    if (grant_rl) begin
      sel_rd   = rl_rd_i;
      sel_data = rl_data_i;
    end else if (grant_div) begin
      sel_rd   = div_rd_i;
      sel_data = div_data_i;
    end
  end

  always_comb begin
    rl_cnt_n    = rl_cnt_r;
    rl_starve_n = rl_starve_r;
    if (grant_rl || !rl_v_i) begin
      rl_cnt_n = '0;
    end else if (rl_cnt_r != max_cnt_lp) begin
      rl_cnt_n = rl_cnt_r + one_cnt_lp;
    end
    if (grant_rl) begin
      rl_starve_n = 1'b0;
    end else if (rl_cnt_n == max_cnt_lp) begin
      rl_starve_n = 1'b1;
    end
  end

  // A starving div that loses to a starving remote keeps its flag and
  // saturated count, so it wins the following cycle.
  always_comb begin
    div_cnt_n    = div_cnt_r;
    div_starve_n = div_starve_r;
    if (grant_div || !div_v_i) begin
      div_cnt_n = '0;
    end else if (div_cnt_r != max_cnt_lp) begin
      div_cnt_n = div_cnt_r + one_cnt_lp;
    end
    if (grant_div) begin
      div_starve_n = 1'b0;
    end else if (div_cnt_n == max_cnt_lp) begin
      div_starve_n = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rl_cnt_r     <= '0;
      div_cnt_r    <= '0;
      rl_starve_r  <= 1'b0;
      div_starve_r <= 1'b0;
    end else begin
      rl_cnt_r     <= rl_cnt_n;
      div_cnt_r    <= div_cnt_n;
      rl_starve_r  <= rl_starve_n;
      div_starve_r <= div_starve_n;
    end
  end

  // x0 writes are consumed but never reach the regfile; scoreboard clears
  // still fire for them since the long-latency op was tracked by rd.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rf_w_v_r    <= 1'b0;
      rf_w_addr_r <= '0;
      rf_w_data_r <= '0;
      sb_clr_v_r  <= 1'b0;
      sb_clr_id_r <= '0;
    end else begin
      rf_w_v_r   <= grant_any && (sel_rd != '0);
      sb_clr_v_r <= grant_long;
      if (grant_any) begin
        rf_w_addr_r <= sel_rd;
        rf_w_data_r <= sel_data;
      end
      if (grant_long) begin
        sb_clr_id_r <= sel_rd;
      end
    end
  end

  assign wb_yumi_o   = grant_wb;
  assign rl_yumi_o   = grant_rl;
  assign div_yumi_o  = grant_div;
  assign rf_w_v_o    = rf_w_v_r;
  assign rf_w_addr_o = rf_w_addr_r;
  assign rf_w_data_o = rf_w_data_r;
  assign sb_clr_v_o  = sb_clr_v_r;
  assign sb_clr_id_o = sb_clr_id_r;

`ifndef SYNTHESIS
  a_one_yumi: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0({wb_yumi_o, rl_yumi_o, div_yumi_o}));
  a_wb_yumi_v: assert property (@(posedge clk_i) disable iff (reset_i)
    wb_yumi_o |-> wb_v_i);
  a_rl_yumi_v: assert property (@(posedge clk_i) disable iff (reset_i)
    rl_yumi_o |-> rl_v_i);
  a_div_yumi_v: assert property (@(posedge clk_i) disable iff (reset_i)
    div_yumi_o |-> div_v_i);
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_vanilla_int_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_bsg_vanilla_int_wb_arbiter: directed scenarios plus randomized model check
// Revision: 1.0
// ============================================================================
module tb_bsg_vanilla_int_wb_arbiter;

  localparam int MAX = 8;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        wb_v_i, rl_v_i, div_v_i;
  logic [4:0]  wb_rd_i, rl_rd_i, div_rd_i;
  logic [31:0] wb_data_i, rl_data_i, div_data_i;
  logic        wb_yumi_o, rl_yumi_o, div_yumi_o;
  logic        rf_w_v_o, sb_clr_v_o;
  logic [4:0]  rf_w_addr_o, sb_clr_id_o;
  logic [31:0] rf_w_data_o;
  logic [2:0]  yumis;

  int n_checks = 0;
  int n_fail   = 0;

  assign yumis = {wb_yumi_o, rl_yumi_o, div_yumi_o};

  always #5 clk_i = ~clk_i;

  bsg_vanilla_int_wb_arbiter #(
    .data_width_p(32), .reg_addr_width_p(5), .max_wait_p(MAX)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .wb_v_i(wb_v_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .wb_yumi_o(wb_yumi_o),
    .rl_v_i(rl_v_i), .rl_rd_i(rl_rd_i), .rl_data_i(rl_data_i), .rl_yumi_o(rl_yumi_o),
    .div_v_i(div_v_i), .div_rd_i(div_rd_i), .div_data_i(div_data_i), .div_yumi_o(div_yumi_o),
    .rf_w_v_o(rf_w_v_o), .rf_w_addr_o(rf_w_addr_o), .rf_w_data_o(rf_w_data_o),
    .sb_clr_v_o(sb_clr_v_o), .sb_clr_id_o(sb_clr_id_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    wb_v_i = 0; rl_v_i = 0; div_v_i = 0;
    wb_rd_i = 0; rl_rd_i = 0; div_rd_i = 0;
    wb_data_i = 0; rl_data_i = 0; div_data_i = 0;
  endtask

  task automatic test_reset();
    wb_v_i = 1; wb_rd_i = 5'd3; wb_data_i = 32'hA5A5_0003;
    rl_v_i = 1; rl_rd_i = 5'd4; rl_data_i = 32'h4;
    div_v_i = 1; div_rd_i = 5'd6; div_data_i = 32'h6;
    reset_i = 1;
    #2;
    n_checks++; if (yumis !== 3'b000) begin n_fail++; $display("FAIL reset_yumi: got %b expected 000", yumis); end
    n_checks++; if ({rf_w_v_o, sb_clr_v_o, rf_w_addr_o, sb_clr_id_o, rf_w_data_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b sb=%b addr=%h id=%h data=%h expected all 0", rf_w_v_o, sb_clr_v_o, rf_w_addr_o, sb_clr_id_o, rf_w_data_o); end
    tick();
    n_checks++; if ({yumis, rf_w_v_o, sb_clr_v_o} !== 5'b0) begin n_fail++; $display("FAIL reset_edge: got yumi=%b v=%b sb=%b expected 0", yumis, rf_w_v_o, sb_clr_v_o); end
    reset_i = 0;
    #2;
    n_checks++; if (yumis !== 3'b100) begin n_fail++; $display("FAIL post_reset_grant: got %b expected 100", yumis); end
    tick();
    n_checks++; if ({rf_w_v_o, rf_w_addr_o, rf_w_data_o, sb_clr_v_o} !== {1'b1, 5'd3, 32'hA5A5_0003, 1'b0}) begin
      n_fail++; $display("FAIL post_reset_write: got v=%b addr=%h data=%h sb=%b expected 1/03/a5a50003/0", rf_w_v_o, rf_w_addr_o, rf_w_data_o, sb_clr_v_o); end
    clear_inputs();
    tick();
  endtask

  task automatic test_lone_wb();
    wb_v_i = 1; wb_rd_i = 5'd5; wb_data_i = 32'hDEAD_BEEF;
    #2;
    n_checks++; if (yumis !== 3'b100) begin n_fail++; $display("FAIL lone_wb_yumi: got %b expected 100", yumis); end
    tick();
    clear_inputs();
    n_checks++; if ({rf_w_v_o, rf_w_addr_o, rf_w_data_o, sb_clr_v_o} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0}) begin
      n_fail++; $display("FAIL lone_wb_write: got v=%b addr=%h data=%h sb=%b expected 1/05/deadbeef/0", rf_w_v_o, rf_w_addr_o, rf_w_data_o, sb_clr_v_o); end
    tick();
    n_checks++; if ({rf_w_v_o, rf_w_addr_o, rf_w_data_o} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL idle_hold: got v=%b addr=%h data=%h expected 0/05/deadbeef", rf_w_v_o, rf_w_addr_o, rf_w_data_o); end
  endtask

  task automatic test_rl_x0();
    rl_v_i = 1; rl_rd_i = 5'd0; rl_data_i = 32'h1234;
    #2;
    n_checks++; if (yumis !== 3'b010) begin n_fail++; $display("FAIL rl_x0_yumi: got %b expected 010", yumis); end
    tick();
    clear_inputs();
    n_checks++; if ({rf_w_v_o, sb_clr_v_o, sb_clr_id_o} !== {1'b0, 1'b1, 5'd0}) begin
      n_fail++; $display("FAIL rl_x0_result: got v=%b sb=%b id=%h expected 0/1/00", rf_w_v_o, sb_clr_v_o, sb_clr_id_o); end
    tick();
    n_checks++; if (sb_clr_v_o !== 1'b0) begin n_fail++; $display("FAIL sb_clr_pulse: got %b expected 0", sb_clr_v_o); end
  endtask

  task automatic test_rl_starve();
    logic [4:0] rd_e;
    wb_v_i = 1; wb_rd_i = 5'd1; wb_data_i = 32'h11;
    rl_v_i = 1; rl_rd_i = 5'd7; rl_data_i = 32'h77;
    for (int rep = 0; rep < 2; rep++) begin
      rd_e = 5'd7 + 5'(rep);
      for (int i = 1; i <= MAX; i++) begin
        #2;
        n_checks++; if (yumis !== 3'b100) begin n_fail++; $display("FAIL starve_wait rep=%0d cyc=%0d: got %b expected 100", rep, i, yumis); end
        tick();
      end
      #2;
      n_checks++; if (yumis !== 3'b010) begin n_fail++; $display("FAIL starve_grant rep=%0d: got %b expected 010", rep, yumis); end
      tick();
      n_checks++; if ({rf_w_v_o, rf_w_addr_o, sb_clr_v_o, sb_clr_id_o} !== {1'b1, rd_e, 1'b1, rd_e}) begin
        n_fail++; $display("FAIL starve_result rep=%0d: got v=%b addr=%h sb=%b id=%h expected rd=%h", rep, rf_w_v_o, rf_w_addr_o, sb_clr_v_o, sb_clr_id_o, rd_e); end
      if (rep == 0) begin rl_rd_i = 5'd8; rl_data_i = 32'h88; end
      else rl_v_i = 0;
    end
    #2;
    n_checks++; if (yumis !== 3'b100) begin n_fail++; $display("FAIL starve_wb_retry: got %b expected 100", yumis); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_both_starve();
    wb_v_i = 1; wb_rd_i = 5'd2; wb_data_i = 32'h22;
    rl_v_i = 1; rl_rd_i = 5'd9; rl_data_i = 32'h99;
    div_v_i = 1; div_rd_i = 5'd10; div_data_i = 32'hAA;
    for (int i = 1; i <= MAX; i++) begin
      #2;
      n_checks++; if (yumis !== 3'b100) begin n_fail++; $display("FAIL both_wait cyc=%0d: got %b expected 100", i, yumis); end
      tick();
    end
    #2;
    n_checks++; if (yumis !== 3'b010) begin n_fail++; $display("FAIL both_rl_first: got %b expected 010", yumis); end
    tick();
    rl_v_i = 0;
    n_checks++; if ({sb_clr_v_o, sb_clr_id_o, rf_w_addr_o} !== {1'b1, 5'd9, 5'd9}) begin
      n_fail++; $display("FAIL both_rl_sb: got sb=%b id=%h addr=%h expected 1/09/09", sb_clr_v_o, sb_clr_id_o, rf_w_addr_o); end
    #2;
    n_checks++; if (yumis !== 3'b001) begin n_fail++; $display("FAIL both_div_next: got %b expected 001", yumis); end
    tick();
    div_v_i = 0;
    n_checks++; if ({sb_clr_v_o, sb_clr_id_o, rf_w_addr_o, rf_w_data_o} !== {1'b1, 5'd10, 5'd10, 32'hAA}) begin
      n_fail++; $display("FAIL both_div_sb: got sb=%b id=%h addr=%h data=%h expected 1/0a/0a/aa", sb_clr_v_o, sb_clr_id_o, rf_w_addr_o, rf_w_data_o); end
    #2;
    n_checks++; if (yumis !== 3'b100) begin n_fail++; $display("FAIL both_wb_after: got %b expected 100", yumis); end
    tick();
    n_checks++; if ({sb_clr_v_o, rf_w_v_o, rf_w_addr_o} !== {1'b0, 1'b1, 5'd2}) begin
      n_fail++; $display("FAIL both_wb_write: got sb=%b v=%b addr=%h expected 0/1/02", sb_clr_v_o, rf_w_v_o, rf_w_addr_o); end
    clear_inputs();
    tick();
  endtask

  task automatic test_rl_div_no_wb();
    rl_v_i = 1; rl_rd_i = 5'd11; rl_data_i = 32'h0B0B;
    div_v_i = 1; div_rd_i = 5'd12; div_data_i = 32'h0C0C;
    #2;
    n_checks++; if (yumis !== 3'b010) begin n_fail++; $display("FAIL nowb_rl: got %b expected 010", yumis); end
    tick();
    rl_v_i = 0;
    n_checks++; if ({rf_w_v_o, rf_w_addr_o, rf_w_data_o} !== {1'b1, 5'd11, 32'h0B0B}) begin
      n_fail++; $display("FAIL nowb_rl_write: got v=%b addr=%h data=%h expected 1/0b/0b0b", rf_w_v_o, rf_w_addr_o, rf_w_data_o); end
    #2;
    n_checks++; if (yumis !== 3'b001) begin n_fail++; $display("FAIL nowb_div: got %b expected 001", yumis); end
    tick();
    div_v_i = 0;
    n_checks++; if ({rf_w_v_o, rf_w_addr_o, rf_w_data_o} !== {1'b1, 5'd12, 32'h0C0C}) begin
      n_fail++; $display("FAIL nowb_div_write: got v=%b addr=%h data=%h expected 1/0c/0c0c", rf_w_v_o, rf_w_addr_o, rf_w_data_o); end
    tick();
    clear_inputs();
  endtask

  // Reference: each requester counts the cycles it has been refused since it
  // became valid; once that reaches MAX it outranks WB until served.
  task automatic test_random();
    int rl_lost, div_lost, g, last_g;
    logic [2:0]  exp_y;
    logic [4:0]  g_rd, prev_addr;
    logic [31:0] g_data, prev_data;
    bit have_prev;
    clear_inputs();
    tick();
    rl_lost = 0; div_lost = 0; last_g = 0; have_prev = 0;
    prev_addr = '0; prev_data = '0;
    for (int c = 0; c < 800; c++) begin
      if (!wb_v_i || last_g == 1) begin
        wb_v_i = ($urandom_range(0, 9) < 7); wb_rd_i = 5'($urandom); wb_data_i = $urandom;
      end
      if (!rl_v_i || last_g == 2) begin
        rl_v_i = ($urandom_range(0, 3) == 0); rl_rd_i = 5'($urandom); rl_data_i = $urandom;
      end
      if (!div_v_i || last_g == 3) begin
        div_v_i = ($urandom_range(0, 4) == 0); div_rd_i = 5'($urandom); div_data_i = $urandom;
      end
      if (rl_v_i && rl_lost >= MAX)        g = 2;
      else if (div_v_i && div_lost >= MAX) g = 3;
      else if (wb_v_i)                     g = 1;
      else if (rl_v_i)                     g = 2;
      else if (div_v_i)                    g = 3;
      else                                 g = 0;
      exp_y = {g == 1, g == 2, g == 3};
      g_rd   = (g == 2) ? rl_rd_i   : (g == 3) ? div_rd_i   : wb_rd_i;
      g_data = (g == 2) ? rl_data_i : (g == 3) ? div_data_i : wb_data_i;
      #3;
      n_checks++; if (yumis !== exp_y) begin n_fail++; $display("FAIL rand_yumi cyc=%0d: got %b expected %b", c, yumis, exp_y); end
      tick();
      n_checks++; if (rf_w_v_o !== (g != 0 && g_rd != 0)) begin n_fail++; $display("FAIL rand_wv cyc=%0d: got %b expected %b", c, rf_w_v_o, (g != 0 && g_rd != 0)); end
      if (g != 0) begin
        n_checks++; if ({rf_w_addr_o, rf_w_data_o} !== {g_rd, g_data}) begin
          n_fail++; $display("FAIL rand_wdata cyc=%0d: got %h/%h expected %h/%h", c, rf_w_addr_o, rf_w_data_o, g_rd, g_data); end
        prev_addr = g_rd; prev_data = g_data; have_prev = 1;
      end else if (have_prev) begin
        n_checks++; if ({rf_w_addr_o, rf_w_data_o} !== {prev_addr, prev_data}) begin
          n_fail++; $display("FAIL rand_hold cyc=%0d: got %h/%h expected %h/%h", c, rf_w_addr_o, rf_w_data_o, prev_addr, prev_data); end
      end
      n_checks++; if (sb_clr_v_o !== (g == 2 || g == 3)) begin n_fail++; $display("FAIL rand_sbv cyc=%0d: got %b expected %b", c, sb_clr_v_o, (g == 2 || g == 3)); end
      if (g == 2 || g == 3) begin
        n_checks++; if (sb_clr_id_o !== g_rd) begin n_fail++; $display("FAIL rand_sbid cyc=%0d: got %h expected %h", c, sb_clr_id_o, g_rd); end
      end
      rl_lost  = (g == 2 || !rl_v_i)  ? 0 : rl_lost + 1;
      div_lost = (g == 3 || !div_v_i) ? 0 : div_lost + 1;
      last_g = g;
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    reset_i = 1;
    clear_inputs();
    #12;
    test_reset();
    test_lone_wb();
    test_rl_x0();
    test_rl_starve();
    test_both_starve();
    test_rl_div_no_wb();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
